// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered occupancy, level flags and
// one-cycle overflow/underflow pulses on rejected requests.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0] DepthLvl = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfLvl    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeLvl    = CntW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic push;
  logic pop;

  // A pop on a full FIFO frees the slot the concurrent push lands in.
  always_comb begin
    push = wr_en && (!full_q || rd_en);
    pop  = rd_en && !empty_q;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flags decoded from next count so they land on the same edge as the update.
    full_d         = (count_d == DepthLvl);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AfLvl);
    almost_empty_d = (count_d <= AeLvl);

    overflow_d  = wr_en && !push;
    underflow_d = rd_en && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign data_out     = data_out_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: fill/drain boundaries, simultaneous push/pop,
// pointer wrap and asynchronous reset mid-operation.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b want 0", almost_full); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b want 1", almost_empty); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", data_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got %b want 0", underflow); end
  endtask

  task automatic test_fill;
    logic [7:0] d;
    for (int i = 1; i <= 16; i++) begin
      d = 8'(i);
      drive(1'b1, d, 1'b0);
      n_checks++; if (count !== 5'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
      if (i == 1) begin
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty_fall got %b want 0", empty); end
      end
      if (i == 13) begin
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL fill_af13 got %b want 0", almost_full); end
      end
      if (i == 14) begin
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af14 got %b want 1", almost_full); end
      end
      if (i == 15) begin
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_full15 got %b want 0", full); end
      end
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b want 0", empty); end
    drive(1'b1, 8'hAA, 1'b0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b want 1", overflow); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", count); end
    drive(1'b0, 8'h00, 1'b0);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_drain;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_checks++; if (data_out !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, data_out, 8'(i)); end
      if (i == 13) begin
        n_checks++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL drain_ae13 got %b want 0", almost_empty); end
      end
      if (i == 14) begin
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL drain_ae14 got %b want 1", almost_empty); end
      end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL drain_count got %0d want 0", count); end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_pulse got %b want 1", underflow); end
    n_checks++; if (data_out !== 8'h10) begin n_fail++; $display("FAIL unf_hold got %h want 10", data_out); end
    drive(1'b0, 8'h00, 1'b0);
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b want 0", underflow); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h21 + i), 1'b0);
    drive(1'b1, 8'h26, 1'b1);
    n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL sim5_count got %0d want 5", count); end
    n_checks++; if (data_out !== 8'h21) begin n_fail++; $display("FAIL sim5_data got %h want 21", data_out); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_checks++; if (data_out !== 8'(8'h22 + i)) begin n_fail++; $display("FAIL sim5_drain[%0d] got %h want %h", i, data_out, 8'(8'h22 + i)); end
    end

    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
    drive(1'b1, 8'h55, 1'b1);
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL simfull_count got %0d want 16", count); end
    n_checks++; if (data_out !== 8'h40) begin n_fail++; $display("FAIL simfull_data got %h want 40", data_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simfull_ovf got %b want 0", overflow); end
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_checks++; if (data_out !== ((i == 16) ? 8'h55 : 8'(8'h40 + i))) begin
        n_fail++; $display("FAIL simfull_drain[%0d] got %h want %h", i, data_out, (i == 16) ? 8'h55 : 8'(8'h40 + i));
      end
    end

    drive(1'b1, 8'h33, 1'b1);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL simempty_unf got %b want 1", underflow); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL simempty_count got %0d want 1", count); end
    n_checks++; if (data_out !== 8'h55) begin n_fail++; $display("FAIL simempty_hold got %h want 55", data_out); end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++; if (data_out !== 8'h33) begin n_fail++; $display("FAIL simempty_pop got %h want 33", data_out); end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        d = 8'(8'h80 + 10 * r + i);
        drive(1'b1, d, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
        d = 8'(8'h80 + 10 * r + i);
        drive(1'b0, 8'h00, 1'b1);
        n_checks++; if (data_out !== d) begin n_fail++; $display("FAIL wrap_data[%0d][%0d] got %h want %h", r, i, data_out, d); end
      end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty[%0d] got %b want 1", r, empty); end
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
    n_checks++; if (count !== 5'd7) begin n_fail++; $display("FAIL arst_pre_count got %0d want 7", count); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL arst_count got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty got %b want 1", empty); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL arst_ae got %b want 1", almost_empty); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL arst_dout got %h want 00", data_out); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h77, 1'b0);
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL arst_push_count got %0d want 1", count); end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++; if (data_out !== 8'h77) begin n_fail++; $display("FAIL arst_pop got %h want 77", data_out); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty_after got %b want 1", empty); end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL arst_no_stale_unf got %b want 1", underflow); end
    n_checks++; if (data_out !== 8'h77) begin n_fail++; $display("FAIL arst_no_stale_data got %h want 77", data_out); end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
